// File: rtl/seg_pkg.sv
// Shared types and frame layout for the 7-segment display path.
// Encoder and serial transmitter both import this package.
package seg_pkg;

    localparam int SEG_FRAME_W = 64;
    localparam int SEG_DIGIT_W = 8;
    localparam int SEG_DIGITS  = SEG_FRAME_W / SEG_DIGIT_W;

    // Bit positions inside one digit byte {a,b,c,d,e,f,g,p}
    localparam int SEG_A = 7;
    localparam int SEG_B = 6;
    localparam int SEG_C = 5;
    localparam int SEG_D = 4;
    localparam int SEG_E = 3;
    localparam int SEG_F = 2;
    localparam int SEG_G = 1;
    localparam int SEG_P = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_LATCH,
        ST_DONE
    } seg_state_t;

    // Digit 0 is leftmost and sits in the top byte of the frame
    function automatic int seg_digit_lsb(input int d);
        return (SEG_DIGITS - 1 - d) * SEG_DIGIT_W;
    endfunction

    function automatic int seg_digit_msb(input int d);
        return seg_digit_lsb(d) + SEG_DIGIT_W - 1;
    endfunction

endpackage

// File: rtl/seg_phase_timer.sv
// Reloadable down-counter that times each serial phase.
// expire is high during the last cycle of a DIV-cycle phase.
module seg_phase_timer #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(DIV);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = (cnt == CW'(1));

endmodule

// File: rtl/seg_shift_out.sv
// Serial transmitter shifting a 64-bit segment frame into a
// 74HC595-style chain, LSB first, with a latch pulse at the end.
module seg_shift_out
    import seg_pkg::*;
#(
    parameter int DIV    = 2,
    parameter int NBITS  = SEG_FRAME_W,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] seg_txt,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             seg_clk,
    output logic             seg_dat,
    output logic             seg_pen,
    output logic             seg_clrn
);

    seg_state_t       state;
    logic [NBITS-1:0] sr;
    logic [6:0]       bit_cnt;
    logic             load;
    logic             expire;

    // Reload on every phase entry; LATCH exit goes straight to DONE
    assign load = ((state == ST_IDLE) && start)
               || (((state == ST_LOW) || (state == ST_HIGH)) && expire);

    seg_phase_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg_clk  <= 1'b0;
            seg_dat  <= 1'b0;
            seg_pen  <= 1'b0;
            seg_clrn <= 1'b0;
        end else begin
            seg_clrn <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr      <= seg_txt ^ {NBITS{INVERT}};
                        bit_cnt <= '0;
                        seg_dat <= seg_txt[0] ^ INVERT;
                        busy    <= 1'b1;
                        state   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (expire) begin
                        seg_clk <= 1'b1;
                        state   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (expire) begin
                        sr      <= sr >> 1;
                        bit_cnt <= bit_cnt + 7'd1;
                        seg_clk <= 1'b0;
                        if (bit_cnt == 7'(NBITS - 1)) begin
                            seg_dat <= 1'b0;
                            seg_pen <= 1'b1;
                            state   <= ST_LATCH;
                        end else begin
                            seg_dat <= sr[1];
                            state   <= ST_LOW;
                        end
                    end
                end
                ST_LATCH: begin
                    if (expire) begin
                        seg_pen <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_shift_out.sv
// Bench for seg_shift_out: frame-offset model checked every cycle
// plus literal expectations on reassembled frames and timing.
module tb_seg_shift_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start;
    logic [63:0] txt [2];
    logic [1:0]  busy, done, sclk, sdat, spen, sclrn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_shift_out #(.DIV(2), .NBITS(64), .INVERT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .seg_txt(txt[0]), .start(start[0]),
        .busy(busy[0]), .done(done[0]), .seg_clk(sclk[0]),
        .seg_dat(sdat[0]), .seg_pen(spen[0]), .seg_clrn(sclrn[0])
    );

    seg_shift_out #(.DIV(1), .NBITS(64), .INVERT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .seg_txt(txt[1]), .start(start[1]),
        .busy(busy[1]), .done(done[1]), .seg_clk(sclk[1]),
        .seg_dat(sdat[1]), .seg_pen(spen[1]), .seg_clrn(sclrn[1])
    );

    function automatic int dv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic inv(input int i);
        return (i == 1);
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, i, a, e);
        end
    endtask

    // Model: a frame is a start cycle plus captured data; outputs
    // follow from the cycle offset j since acceptance.
    int          cyc = 0;
    bit          act [2];
    int          s [2];
    logic [63:0] fr [2];
    bit          clrn_m = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act[0] = 1'b0;
            act[1] = 1'b0;
            clrn_m = 1'b0;
        end else begin
            cyc++;
            clrn_m = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if ((!act[i] || (cyc - 1 - s[i]) > 129 * dv(i)) && start[i]) begin
                    act[i] = 1'b1;
                    s[i]   = cyc;
                    fr[i]  = txt[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int   j, d;
            logic eb, ed, ec, ep;
            d  = dv(i);
            j  = cyc - s[i];
            eb = act[i] && (j < 129 * d);
            ed = act[i] && (j == 129 * d);
            ep = act[i] && (j >= 128 * d) && (j < 129 * d);
            ec = act[i] && (j < 128 * d) && ((j % (2 * d)) >= d);
            chk("busy", i, busy[i], eb);
            chk("done", i, done[i], ed);
            chk("seg_clk", i, sclk[i], ec);
            chk("seg_pen", i, spen[i], ep);
            chk("seg_clrn", i, sclrn[i], clrn_m);
            if (act[i] && (j < 128 * d))
                chk("seg_dat", i, sdat[i], fr[i][j / (2 * d)] ^ inv(i));
            else if (!rst_n)
                chk("seg_dat_rst", i, sdat[i], 0);
        end
    end

    // Observers: reassemble bits on seg_clk rising edges and time events
    logic [63:0] asm_ [2];
    int redge [2], pen_n [2], busy_n [2], done_n [2];
    int last_rise [2], pen_first [2], busy_first [2], done_at [2];
    logic [1:0] pclk = 2'b00;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sclk[i] && !pclk[i]) begin
                if (redge[i] < 64) asm_[i][redge[i]] = sdat[i];
                redge[i]++;
                last_rise[i] = cyc;
            end
            pclk[i] = sclk[i];
            if (spen[i]) begin
                pen_n[i]++;
                if (pen_first[i] < 0) pen_first[i] = cyc;
            end
            if (busy[i]) begin
                busy_n[i]++;
                if (busy_first[i] < 0) busy_first[i] = cyc;
            end
            if (done[i]) begin
                done_n[i]++;
                done_at[i] = cyc;
            end
        end
    end

    task automatic clr_mon(input int i);
        asm_[i]       = '0;
        redge[i]      = 0;
        pen_n[i]      = 0;
        busy_n[i]     = 0;
        done_n[i]     = 0;
        last_rise[i]  = -1;
        pen_first[i]  = -1;
        busy_first[i] = -1;
        done_at[i]    = -1;
    endtask

    // Leaves with start held for the next posedge; returns its cycle
    task automatic launch(input int i, input logic [63:0] t, output int sc);
        @(negedge clk);
        clr_mon(i);
        txt[i]   = t;
        start[i] = 1'b1;
        sc       = cyc + 1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        while (!done[i] && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!done[i]) begin
            checks++;
            errors++;
            $display("FAIL wait_done[%0d] timeout after %0d cycles", i, budget);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout reached");
        $fatal(1, "global timeout");
    end

    initial begin
        int sc, dd, n;
        start  = 2'b00;
        txt[0] = '0;
        txt[1] = '0;
        clr_mon(0);
        clr_mon(1);
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_clrn", 0, sclrn[0], 0);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_pen", 1, spen[1], 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("clrn_release", 0, sclrn[0], 1);
        chk("clrn_release", 1, sclrn[1], 1);

        // Basic frame, DIV=2
        launch(0, 64'h0123_4567_89AB_CDEF, sc);
        wait_done(0, 400);
        repeat (3) @(negedge clk);
        #1;
        chk("rise_count", 0, redge[0], 64);
        chk("frame", 0, asm_[0], 64'h0123_4567_89AB_CDEF);
        chk("busy_len", 0, busy_n[0], 258);
        chk("busy_first", 0, busy_first[0] - sc, 0);
        chk("done_off", 0, done_at[0] - sc, 258);
        chk("pen_len", 0, pen_n[0], 2);
        chk("pen_after_rise", 0, pen_first[0] - last_rise[0], 2);
        chk("done_count", 0, done_n[0], 1);

        // Inverted data, DIV=1
        launch(1, 64'hFFFF_0000_FFFF_0000, sc);
        wait_done(1, 200);
        repeat (3) @(negedge clk);
        #1;
        chk("rise_count", 1, redge[1], 64);
        chk("frame_inv", 1, asm_[1], 64'h0000_FFFF_0000_FFFF);
        chk("busy_len", 1, busy_n[1], 129);
        chk("done_off", 1, done_at[1] - sc, 129);
        chk("pen_len", 1, pen_n[1], 1);

        // Starts while busy and seg_txt churn are ignored
        launch(0, 64'hDEAD_BEEF_0BAD_F00D, sc);
        repeat (9) @(negedge clk);
        start[0] = 1'b1;
        txt[0]   = 64'h1111_2222_3333_4444;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (40) @(negedge clk);
        txt[0] = 64'h5555_6666_7777_8888;
        repeat (149) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 400);
        repeat (6) @(negedge clk);
        #1;
        chk("frame_busy_start", 0, asm_[0], 64'hDEAD_BEEF_0BAD_F00D);
        chk("done_count_busy", 0, done_n[0], 1);
        chk("busy_len_busy", 0, busy_n[0], 258);

        // Back-to-back: start on the cycle after done
        launch(0, 64'h0F1E_2D3C_4B5A_6978, sc);
        wait_done(0, 400);
        dd = cyc;
        @(negedge clk);
        clr_mon(0);
        txt[0]   = 64'h8796_A5B4_C3D2_E1F0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 400);
        repeat (3) @(negedge clk);
        #1;
        chk("b2b_gap", 0, busy_first[0] - dd, 2);
        chk("b2b_frame", 0, asm_[0], 64'h8796_A5B4_C3D2_E1F0);
        chk("b2b_rises", 0, redge[0], 64);

        // Reset in the middle of bit 30
        launch(0, 64'hA5A5_5A5A_C3C3_3C3C, sc);
        n = 0;
        while (redge[0] < 30 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit30", 0, redge[0], 30);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 0, busy[0], 0);
        chk("abort_done", 0, done[0], 0);
        chk("abort_clk", 0, sclk[0], 0);
        chk("abort_dat", 0, sdat[0], 0);
        chk("abort_pen", 0, spen[0], 0);
        chk("abort_clrn", 0, sclrn[0], 0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("clrn_held", 0, sclrn[0], 0);
        @(negedge clk);
        #1;
        chk("clrn_after", 0, sclrn[0], 1);
        chk("abort_pen_count", 0, pen_n[0], 0);
        chk("abort_done_count", 0, done_n[0], 0);
        launch(0, 64'h3C3C_C3C3_5A5A_A5A5, sc);
        wait_done(0, 400);
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_frame", 0, asm_[0], 64'h3C3C_C3C3_5A5A_A5A5);
        chk("post_rst_rises", 0, redge[0], 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
